// File: rtl/key_debounce_event.sv
// key_debounce_event: turns raw active-low keys into debounced levels and 1-cycle press/release/long/repeat events.
// Latency: a clean pin edge reaches key_level_o and press/release DB_CYC+2 cycles later; long fires LONG_CYC after press.
// Backpressure: none, events are single-cycle pulses that are never held; macro KEY_REPEAT_EN enables auto-repeat.
module key_debounce_event #(
    parameter int NUM_KEYS    = 2,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_i,
    output logic [NUM_KEYS-1:0] key_level_o,
    output logic [NUM_KEYS-1:0] key_press_o,
    output logic [NUM_KEYS-1:0] key_release_o,
    output logic [NUM_KEYS-1:0] key_long_o,
    output logic [NUM_KEYS-1:0] key_repeat_o
);
    localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;
    localparam int DB_W     = $clog2(DB_CYC + 1);
    localparam int HOLD_W   = $clog2(LONG_CYC + 1);
`ifdef KEY_REPEAT_EN
    localparam int REP_CYC  = CLK_HZ / 1000 * REPEAT_MS;
    localparam int REP_W    = $clog2(REP_CYC + 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } hold_state_t;

    // Reject timing combinations that would make the long-press unreachable or the debounce degenerate.
    generate
        if (DEBOUNCE_MS < 1 || LONG_MS <= DEBOUNCE_MS || REPEAT_MS < 1) begin : g_param_check
            $error("key_debounce_event: need DEBOUNCE_MS >= 1, LONG_MS > DEBOUNCE_MS, REPEAT_MS >= 1");
        end
    endgenerate

    genvar k;
    generate
        for (k = 0; k < NUM_KEYS; k++) begin : g_key
            logic [1:0]        sync_q;       // sync_q[1] is the synchronized pin
            logic              stable_q;     // debounced pin value, 1 = released
            logic [DB_W-1:0]   db_cnt_q;
            logic              db_hit;
            logic              acc_press;
            logic              acc_release;
            logic              press_q;
            logic              release_q;
            hold_state_t       state_q;
            hold_state_t       state_d;
            logic [HOLD_W-1:0] hold_q;
            logic [HOLD_W-1:0] hold_d;
            logic              long_q;
            logic              long_d;
`ifdef KEY_REPEAT_EN
            logic [REP_W-1:0]  rep_q;
            logic [REP_W-1:0]  rep_d;
            logic              repeat_q;
            logic              repeat_d;
`endif

            // The pin differs from the accepted value for the full window: accept it this cycle.
            assign db_hit      = (sync_q[1] != stable_q) && (db_cnt_q == DB_W'(DB_CYC - 1));
            assign acc_press   = db_hit && !sync_q[1];
            assign acc_release = db_hit && sync_q[1];

            // Two-flop synchronizer; resets to the released level.
            always_ff @(posedge sys_clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= 2'b11;
                end else begin
                    sync_q <= {sync_q[0], key_i[k]};
                end
            end

            // Debounce: any return to the accepted value restarts the stability window.
            always_ff @(posedge sys_clk or negedge rst_n) begin
                if (!rst_n) begin
                    stable_q <= 1'b1;
                    db_cnt_q <= '0;
                end else if (sync_q[1] == stable_q) begin
                    db_cnt_q <= '0;
                end else if (db_hit) begin
                    stable_q <= sync_q[1];
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end

            // Press/release pulses are registered so they line up with the key_level_o change.
            always_ff @(posedge sys_clk or negedge rst_n) begin
                if (!rst_n) begin
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    press_q   <= acc_press;
                    release_q <= acc_release;
                end
            end

            // Hold FSM state, counters and registered long/repeat pulses.
            always_ff @(posedge sys_clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q  <= IDLE;
                    hold_q   <= '0;
                    long_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
                    rep_q    <= '0;
                    repeat_q <= 1'b0;
`endif
                end else begin
                    state_q  <= state_d;
                    hold_q   <= hold_d;
                    long_q   <= long_d;
`ifdef KEY_REPEAT_EN
                    rep_q    <= rep_d;
                    repeat_q <= repeat_d;
`endif
                end
            end

            // Hold FSM next state; an accepted release overrides everything, including a coincident long/repeat.
            always_comb begin
                state_d  = state_q;
                hold_d   = hold_q;
                long_d   = 1'b0;
`ifdef KEY_REPEAT_EN
                rep_d    = rep_q;
                repeat_d = 1'b0;
`endif
                case (state_q)
                    IDLE: begin
                        if (acc_press) begin
                            state_d = HELD;
                            hold_d  = '0;
                        end
                    end
                    HELD: begin
                        if (hold_q == HOLD_W'(LONG_CYC - 1)) begin
                            long_d  = 1'b1;
                            state_d = LONG;
                            hold_d  = '0;
`ifdef KEY_REPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                    LONG: begin
`ifdef KEY_REPEAT_EN
                        if (rep_q == REP_W'(REP_CYC - 1)) begin
                            repeat_d = 1'b1;
                            rep_d    = '0;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
`endif
                    end
                    default: begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                endcase
                if (acc_release) begin
                    state_d  = IDLE;
                    hold_d   = '0;
                    long_d   = 1'b0;
`ifdef KEY_REPEAT_EN
                    rep_d    = '0;
                    repeat_d = 1'b0;
`endif
                end
            end

            assign key_level_o[k]   = ~stable_q;
            assign key_press_o[k]   = press_q;
            assign key_release_o[k] = release_q;
            assign key_long_o[k]    = long_q;
`ifdef KEY_REPEAT_EN
            assign key_repeat_o[k]  = repeat_q;
`endif
        end
    endgenerate

`ifndef KEY_REPEAT_EN
    assign key_repeat_o = '0;
`endif

endmodule

// File: tb/tb_key_debounce_event.sv
// tb_key_debounce_event: directed and random key stimulus against a window/age based reference model.
// Expected outputs are queued per cycle by the stimulus; a monitor pops and compares one entry per clock.
// Runs with or without KEY_REPEAT_EN; the model follows the same macro.
module tb_key_debounce_event;
    localparam int NK   = 2;
    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;
`ifdef KEY_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic [NK-1:0] key_i   = '1;
    logic [NK-1:0] key_level_o;
    logic [NK-1:0] key_press_o;
    logic [NK-1:0] key_release_o;
    logic [NK-1:0] key_long_o;
    logic [NK-1:0] key_repeat_o;

    always #5 sys_clk = ~sys_clk;

    key_debounce_event #(
        .NUM_KEYS(NK), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(5)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .key_i(key_i),
        .key_level_o(key_level_o),
        .key_press_o(key_press_o),
        .key_release_o(key_release_o),
        .key_long_o(key_long_o),
        .key_repeat_o(key_repeat_o)
    );

    typedef struct packed {
        logic [NK-1:0] level;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] lng;
        logic [NK-1:0] rep;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    // Reference model: raw samples per key (index 0 newest), accepted level, press time.
    logic hist [NK][6];
    logic m_stable [NK];
    logic m_held [NK];
    int   press_edge [NK];
    int   edge_n = 0;

    task automatic model_reset();
        for (int kk = 0; kk < NK; kk++) begin
            for (int j = 0; j < 6; j++) hist[kk][j] = 1'b1;
            m_stable[kk] = 1'b1;
            m_held[kk]   = 1'b0;
            press_edge[kk] = 0;
        end
    endtask

    // Drive one cycle of inputs (called just after a falling edge) and queue the response to the next rising edge.
    task automatic step(input logic [NK-1:0] k, input logic r);
        exp_t e;
        logic want;
        bit   all_same;
        int   age;
        e = '0;
        key_i = k;
        rst_n = r;
        edge_n++;
        if (!r) begin
            model_reset();
        end else begin
            for (int kk = 0; kk < NK; kk++) begin
                for (int j = 5; j > 0; j--) hist[kk][j] = hist[kk][j-1];
                hist[kk][0] = k[kk];
                // The debouncer sees samples delayed by two synchronizer stages; it needs DB agreeing samples.
                want = ~m_stable[kk];
                all_same = 1'b1;
                for (int j = 2; j < 2 + DB; j++) if (hist[kk][j] != want) all_same = 1'b0;
                if (all_same) begin
                    m_stable[kk] = want;
                    if (want == 1'b0) e.press[kk] = 1'b1;
                    else e.rel[kk] = 1'b1;
                end
                if (e.rel[kk]) begin
                    m_held[kk] = 1'b0;
                end else if (m_held[kk]) begin
                    age = edge_n - press_edge[kk];
                    if (age == LONG) e.lng[kk] = 1'b1;
                    if (REP_ON && age > LONG && ((age - LONG) % REP) == 0) e.rep[kk] = 1'b1;
                end
                if (e.press[kk]) begin
                    m_held[kk] = 1'b1;
                    press_edge[kk] = edge_n;
                end
                e.level[kk] = ~m_stable[kk];
            end
        end
        sb_q.push_back(e);
        @(negedge sys_clk);
    endtask

    task automatic hold(input logic [NK-1:0] k, input logic r, input int n);
        for (int i = 0; i < n; i++) step(k, r);
    endtask

    task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp_v);
        end
    endtask

    // Monitor: one comparison set per rising edge that has a queued expectation.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            cyc++;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("level",   key_level_o,   e.level);
                check("press",   key_press_o,   e.press);
                check("release", key_release_o, e.rel);
                check("long",    key_long_o,    e.lng);
                check("repeat",  key_repeat_o,  e.rep);
            end
        end
    end

    // Stimulus: directed scenarios first, then random bouncy traffic with occasional resets.
    initial begin
        int            run [NK];
        logic [NK-1:0] cur;
        model_reset();
        @(negedge sys_clk);
        hold(2'b11, 1'b0, 3);
        hold(2'b11, 1'b1, 100);
        // Short clean press on key 0.
        hold(2'b10, 1'b1, 10);
        hold(2'b11, 1'b1, 20);
        // Key 1 bouncing every 2 cycles.
        for (int i = 0; i < 3; i++) begin
            hold(2'b01, 1'b1, 2);
            hold(2'b11, 1'b1, 2);
        end
        hold(2'b11, 1'b1, 20);
        // Long hold on key 0: long, repeats, release coinciding with a repeat slot.
        hold(2'b10, 1'b1, 40);
        hold(2'b11, 1'b1, 20);
        // Both keys together.
        hold(2'b00, 1'b1, 40);
        hold(2'b11, 1'b1, 20);
        // Reset while key 0 sits in long-press, key kept held across reset exit.
        hold(2'b10, 1'b1, 35);
        hold(2'b10, 1'b0, 3);
        hold(2'b10, 1'b1, 15);
        hold(2'b11, 1'b1, 20);
        // Release one before, exactly at and one after the long threshold.
        hold(2'b10, 1'b1, 19);
        hold(2'b11, 1'b1, 20);
        hold(2'b10, 1'b1, 20);
        hold(2'b11, 1'b1, 20);
        hold(2'b10, 1'b1, 21);
        hold(2'b11, 1'b1, 20);
        // Random runs: mostly glitches or medium holds, sometimes long holds.
        cur = 2'b11;
        for (int kk = 0; kk < NK; kk++) run[kk] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int kk = 0; kk < NK; kk++) begin
                if (run[kk] == 0) begin
                    cur[kk] = ~cur[kk];
                    run[kk] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(3, 50));
                end
                run[kk]--;
            end
            step(cur, ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1);
        end
        hold(2'b11, 1'b1, 20);
        @(posedge sys_clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
